pkt_tuple_parser: RTL

Front-end parser for the traffic feature extractor (TFE). It consumes raw Ethernet frames as a 64-bit beat stream and extracts the 104-bit IPv4 5-tuple plus the first 32 bytes after the L2 header. It emits both, as a single-cycle valid pulse, to the TFE `ip_tuple`/`ip_valid`/`i_raw_feature` inputs. Frames that are not parsable IPv4 are dropped and counted; no output pulse is produced for them.

---
 rtl/pkt_tuple_parser.sv | 137 +++++++++++++
 1 files changed

// File: rtl/pkt_tuple_parser.sv
// pkt_tuple_parser: Ethernet front-end for the traffic feature extractor.
// Captures the frame header from a 64-bit big-endian beat stream and, on
// the s_last beat, decides whether the frame is plain IPv4 (IHL 5). For an
// accepted frame it emits the 5-tuple and the first 32 L3 bytes as a
// one-cycle pulse. Any other frame is dropped and counted.
// Optional feature macro: PARSER_VLAN_EN adds 802.1Q tag handling. The tag
// moves L3 to offset 18, and the header buffer grows to 7 beats.
module pkt_tuple_parser #(
    parameter int DROP_CNT_W = 16,
    parameter int PKT_CNT_W  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [63:0]           s_data,
    input  logic [7:0]            s_keep,
    input  logic                  s_valid,
    input  logic                  s_last,
    output logic [103:0]          ip_tuple,
    output logic [255:0]          i_raw_feature,
    output logic                  ip_valid,
    output logic [DROP_CNT_W-1:0] drop_cnt,
    output logic [PKT_CNT_W-1:0]  pkt_cnt
);

    // state  | meaning
    // S_CAP  | storing beats into the header buffer
    // S_SKIP | header captured; discard beats until s_last
`ifdef PARSER_VLAN_EN
    localparam int NB = 7;
`else
    localparam int NB = 6;
`endif
    localparam int WB = NB * 64;

    typedef enum logic {S_CAP, S_SKIP} state_t;

    state_t         state;
    logic [2:0]     beat_idx;
    logic [5:0]     byte_cnt;
    logic [WB-1:0]  hbuf;

    logic [WB-1:0]  win;
    logic [3:0]     kcnt;
    logic [6:0]     cnt_sum;
    logic [5:0]     cnt_now;
    logic [15:0]    et;
    logic [255:0]   l3;
    logic [5:0]     l3_off;
    logic [7:0]     proto;
    logic [31:0]    ports;
    logic           accept;
    logic [255:0]   feat;
    logic           unused_bits;

    // Header view that includes the beat arriving this cycle, so the s_last beat can be decided in place
    always_comb begin
        win = hbuf;
        if (state == S_CAP) begin
            for (int b = 0; b < NB; b++) begin
                if (beat_idx == 3'(b)) win[WB-1-64*b -: 64] = s_data;
            end
        end
    end

    assign kcnt    = 4'($countones(s_keep));
    assign cnt_sum = {1'b0, byte_cnt} + {3'b0, kcnt};
    assign cnt_now = (cnt_sum > 7'd63) ? 6'd63 : cnt_sum[5:0];

`ifdef PARSER_VLAN_EN
    logic vlan;
    assign vlan        = (win[WB-97 -: 16] == 16'h8100);
    assign et          = vlan ? win[WB-129 -: 16] : win[WB-97 -: 16];
    assign l3          = vlan ? win[WB-145 -: 256] : win[WB-113 -: 256];
    assign l3_off      = vlan ? 6'd18 : 6'd14;
    assign unused_bits = ^{win[WB-1 -: 96], win[47:0]};
`else
    assign et          = win[WB-97 -: 16];
    assign l3          = win[WB-113 -: 256];
    assign l3_off      = 6'd14;
    assign unused_bits = ^{win[WB-1 -: 96], win[15:0]};
`endif

    assign proto  = l3[183:176];
    assign ports  = (proto == 8'd6 || proto == 8'd17) ? l3[95:64] : 32'd0;
    assign accept = (et == 16'h0800) && (l3[255:248] == 8'h45) &&
                    ({1'b0, cnt_now} >= ({1'b0, l3_off} + 7'd24));

    // Feature bytes past the end of the frame read as zero rather than stale buffer contents
    always_comb begin
        feat = '0;
        for (int k = 0; k < 32; k++) begin
            if (({1'b0, l3_off} + 7'(k)) < {1'b0, cnt_now}) feat[255-8*k -: 8] = l3[255-8*k -: 8];
        end
    end

    // Capture FSM, frame decision and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_CAP;
            beat_idx      <= '0;
            byte_cnt      <= '0;
            hbuf          <= '0;
            ip_tuple      <= '0;
            i_raw_feature <= '0;
            ip_valid      <= 1'b0;
            drop_cnt      <= '0;
            pkt_cnt       <= '0;
        end else begin
            ip_valid <= 1'b0;
            if (s_valid) begin
                if (state == S_CAP) begin
                    for (int b = 0; b < NB; b++) begin
                        if (beat_idx == 3'(b)) hbuf[WB-1-64*b -: 64] <= s_data;
                    end
                end
                if (s_last) begin
                    state    <= S_CAP;
                    beat_idx <= '0;
                    byte_cnt <= '0;
                    if (accept) begin
                        ip_valid      <= 1'b1;
                        ip_tuple      <= {l3[159:128], l3[127:96], ports, proto};
                        i_raw_feature <= feat;
                        pkt_cnt       <= pkt_cnt + 1'b1;
                    end else if (drop_cnt != '1) begin
                        drop_cnt <= drop_cnt + 1'b1;
                    end
                end else begin
                    byte_cnt <= cnt_now;
                    if (beat_idx != 3'd7) beat_idx <= beat_idx + 3'd1;
                    if (state == S_CAP && beat_idx == 3'(NB-1)) state <= S_SKIP;
                end
            end
        end
    end

endmodule
